// File: rtl/sort4_stream_pkg.sv
// Shared definitions for the sort4 streaming wrapper: default word width,
// group size and the controller state codes.
package sort4_stream_pkg;

  // Default data word width
  localparam int W_DEFAULT = 4;

  // Maximum number of words collected into one group
  localparam int N_SLOTS = 4;

  // Controller states
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Ascending compare-exchange: returns {min, max}. The caller splits the
  // result with a constant width, so the low half always holds max.
  function automatic logic [63:0] cmp_swap(input logic [31:0] x, input logic [31:0] y);
    cmp_swap = (x <= y) ? {x, y} : {y, x};
  endfunction

endpackage

// File: rtl/sort4_stream_sort4.sv
// Combinational 4-input sorting network (five compare-exchange elements).
// Outputs are ascending: ra_o <= rb_o <= rc_o <= rd_o. Equal inputs may
// leave in either order; the values are identical, so that is harmless.
module sort4_stream_sort4 #(
  parameter int T = 3
) (
  input  logic [T:0] a_i,
  input  logic [T:0] b_i,
  input  logic [T:0] c_i,
  input  logic [T:0] d_i,
  output logic [T:0] ra_o,
  output logic [T:0] rb_o,
  output logic [T:0] rc_o,
  output logic [T:0] rd_o
);

  logic [T:0] lo_ab, hi_ab, lo_cd, hi_cd;
  logic [T:0] min_all, max_all, mid_x, mid_y;

  // Three stages: sort pairs, pick global extremes, order the middle pair
  always_comb begin
    lo_ab   = (a_i <= b_i) ? a_i : b_i;
    hi_ab   = (a_i <= b_i) ? b_i : a_i;
    lo_cd   = (c_i <= d_i) ? c_i : d_i;
    hi_cd   = (c_i <= d_i) ? d_i : c_i;

    min_all = (lo_ab <= lo_cd) ? lo_ab : lo_cd;
    mid_x   = (lo_ab <= lo_cd) ? lo_cd : lo_ab;
    max_all = (hi_ab <= hi_cd) ? hi_cd : hi_ab;
    mid_y   = (hi_ab <= hi_cd) ? hi_ab : hi_cd;

    ra_o    = min_all;
    rb_o    = (mid_x <= mid_y) ? mid_x : mid_y;
    rc_o    = (mid_x <= mid_y) ? mid_y : mid_x;
    rd_o    = max_all;
  end

endmodule

// File: rtl/sort4_stream.sv
// Stream wrapper around the sort4 network. Collects a group of 1..4 words
// from a valid/ready input, sorts it in one cycle, then replays the sorted
// words ascending on a valid/ready output. Loading and draining never overlap.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_LOAD  | accepting words into slots; in_ready high
//   S_SORT  | one cycle: capture network result, present first word
//   S_DRAIN | replay res[0..n_words-1]; output held until consumer takes it
module sort4_stream
  import sort4_stream_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
);

  state_e       state_q;
  logic [1:0]   cnt_q;
  logic [1:0]   idx_q;
  logic [2:0]   n_words_q;
  logic [W-1:0] slot_q [N_SLOTS];
  logic [W-1:0] res_q  [N_SLOTS];
  logic [W-1:0] out_data_q;
  logic         out_valid_q;
  logic         out_last_q;

  logic [W-1:0] s_ra, s_rb, s_rc, s_rd;
  logic         accept;
  logic         transfer;
  logic [2:0]   idx_ext;
  logic [2:0]   last_idx;
  logic [1:0]   idx_d;
  logic         more_words;

  // Empty slots hold all-ones so padding always sorts behind real words;
  // n_words, not the value, decides how many words are replayed.
  sort4_stream_sort4 #(
    .T (W-1)
  ) u_sort4 (
    .a_i  (slot_q[0]),
    .b_i  (slot_q[1]),
    .c_i  (slot_q[2]),
    .d_i  (slot_q[3]),
    .ra_o (s_ra),
    .rb_o (s_rb),
    .rc_o (s_rc),
    .rd_o (s_rd)
  );

  // Handshake qualifiers and drain bookkeeping
  always_comb begin
    in_ready   = (state_q == S_LOAD) && !reset;
    accept     = in_valid && in_ready;
    transfer   = out_valid_q && out_ready;
    idx_ext    = {1'b0, idx_q};
    last_idx   = n_words_q - 3'd1;
    idx_d      = idx_q + 2'd1;
    more_words = (idx_ext < last_idx);
  end

  // Controller: load, sort, drain, with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      cnt_q       <= 2'd0;
      idx_q       <= 2'd0;
      n_words_q   <= 3'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_q[i] <= '1;
        res_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            slot_q[cnt_q] <= in_data;
            cnt_q         <= cnt_q + 2'd1;
            if (in_last || (cnt_q == 2'd3)) begin
              n_words_q <= {1'b0, cnt_q} + 3'd1;
              state_q   <= S_SORT;
            end
          end
        end

        S_SORT: begin
          res_q[0]    <= s_ra;
          res_q[1]    <= s_rb;
          res_q[2]    <= s_rc;
          res_q[3]    <= s_rd;
          idx_q       <= 2'd0;
          out_valid_q <= 1'b1;
          out_data_q  <= s_ra;
          out_last_q  <= (n_words_q == 3'd1);
          state_q     <= S_DRAIN;
        end

        S_DRAIN: begin
          if (transfer) begin
            if (more_words) begin
              idx_q      <= idx_d;
              out_data_q <= res_q[idx_d];
              out_last_q <= ({1'b0, idx_d} == last_idx);
            end else begin
              // Last word taken: clear the group and reopen the input.
              // out_data keeps its last value rather than going undefined.
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              cnt_q       <= 2'd0;
              for (int i = 0; i < N_SLOTS; i++) begin
                slot_q[i] <= '1;
              end
              state_q <= S_LOAD;
            end
          end
        end

        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  // Output drive from registered state
  always_comb begin
    out_data  = out_data_q;
    out_valid = out_valid_q;
    out_last  = out_last_q;
    busy      = (state_q != S_LOAD);
  end

endmodule

// File: tb/tb_sort4_stream.sv
// Self-checking bench for sort4_stream: directed scenarios plus randomized
// groups compared against a plain insertion-sort reference.
module tb_sort4_stream;

  localparam int W = 4;
  typedef logic [W-1:0] word_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;

  int errors = 0;
  int checks = 0;

  word_t got_d[$];
  bit    got_l[$];
  int    stable_err;
  int    ready_err;
  bit    tmo;

  always #5 clk = ~clk;

  sort4_stream #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: ascending sort of the first n words of a group
  function automatic void ref_sort(input word_t w[4], input int n, output word_t r[4]);
    word_t t;
    r = w;
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0; j--) begin
        if (r[j] < r[j-1]) begin
          t = r[j]; r[j] = r[j-1]; r[j-1] = t;
        end
      end
    end
  endfunction

  // Offer n words; last word carries in_last when mark_last is set
  task automatic load_group(input word_t w[4], input int n, input bit mark_last);
    int k;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = (i == n - 1) && mark_last;
      k = 0;
      while (!in_ready && k < 100) begin
        @(posedge clk); #1; k++;
      end
      if (!in_ready) begin
        tmo = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Capture output transfers until n_exp words are seen, plus 4 idle cycles
  task automatic collect(input int n_exp, input bit [0:7] pat, input bit rand_rdy,
                         input bit junk_en, input word_t junk);
    int    k = 0;
    int    extra = 0;
    bit    pv = 1'b0, pr = 1'b0, pl = 1'b0;
    word_t pd = '0;
    got_d.delete();
    got_l.delete();
    stable_err = 0;
    ready_err  = 0;
    tmo        = 1'b0;
    while (extra < 4 && k < 300) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : pat[k % 8];
      if (junk_en) begin
        in_valid = out_valid;
        in_data  = junk;
        in_last  = 1'b1;
        if (out_valid && in_ready) ready_err++;
      end
      if (pv && !pr && out_valid && (out_data !== pd || out_last !== pl)) stable_err++;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      if (got_d.size() >= n_exp) extra++;
      @(posedge clk); #1; k++;
    end
    if (k >= 300) tmo = 1'b1;
    out_ready = 1'b0;
    if (junk_en) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%0d busy=%b want 0 0 0 0", out_valid, out_last, out_data, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_four_word();
    word_t w[4], r[4];
    w = '{4'd9, 4'd3, 4'd12, 4'd3};
    ref_sort(w, 4, r);
    tmo = 1'b0;
    load_group(w, 4, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL four_latency_n1: got v=%b busy=%b want 0 1", out_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL four_latency_n2: got v=%b want 1", out_valid); end
    collect(4, 8'hFF, 1'b0, 1'b0, '0);
    checks++;
    if (tmo || got_d.size() != 4) begin
      errors++; $display("FAIL four_count: got %0d words tmo=%b want 4", got_d.size(), tmo);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_d[i] !== r[i] || got_l[i] !== (i == 3)) begin
          errors++; $display("FAIL four_word%0d: got d=%0d l=%b want d=%0d l=%b", i, got_d[i], got_l[i], r[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_partial();
    word_t w[4], r[4];
    w = '{4'd7, 4'd2, 4'd0, 4'd0};
    ref_sort(w, 2, r);
    tmo = 1'b0;
    load_group(w, 2, 1'b1);
    collect(2, 8'hFF, 1'b0, 1'b0, '0);
    checks++;
    if (tmo || got_d.size() != 2) begin
      errors++; $display("FAIL partial_count: got %0d words want 2", got_d.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_d[i] !== r[i] || got_l[i] !== (i == 1)) begin
          errors++; $display("FAIL partial_word%0d: got d=%0d l=%b want d=%0d l=%b", i, got_d[i], got_l[i], r[i], (i == 1));
        end
      end
    end
    w = '{4'd5, 4'd0, 4'd0, 4'd0};
    load_group(w, 1, 1'b1);
    collect(1, 8'hFF, 1'b0, 1'b0, '0);
    checks++;
    if (tmo || got_d.size() != 1 || got_d[0] !== 4'd5 || got_l[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_word: got n=%0d d=%0d l=%b want n=1 d=5 l=1", got_d.size(),
               (got_d.size() > 0) ? got_d[0] : 4'd0, (got_l.size() > 0) ? got_l[0] : 1'b0);
    end
  endtask

  task automatic test_backpressure();
    word_t w[4], r[4];
    w = '{4'd15, 4'd0, 4'd15, 4'd0};
    ref_sort(w, 4, r);
    tmo = 1'b0;
    load_group(w, 4, 1'b1);
    collect(4, 8'b00101101, 1'b0, 1'b0, '0);
    checks++;
    if (stable_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stable_err); end
    checks++;
    if (tmo || got_d.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d words want 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_d[i] !== r[i] || got_l[i] !== (i == 3)) begin
          errors++; $display("FAIL bp_word%0d: got d=%0d l=%b want d=%0d l=%b", i, got_d[i], got_l[i], r[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_input_during_drain();
    word_t w[4], r[4];
    w = '{4'd10, 4'd5, 4'd0, 4'd0};
    ref_sort(w, 2, r);
    tmo = 1'b0;
    load_group(w, 2, 1'b1);
    collect(2, 8'b10110111, 1'b0, 1'b1, 4'hE);
    checks++;
    if (ready_err != 0) begin errors++; $display("FAIL drain_in_ready: got %0d cycles high want 0", ready_err); end
    checks++;
    if (tmo || got_d.size() != 2 || got_d[0] !== r[0] || got_d[1] !== r[1]) begin
      errors++; $display("FAIL drain_junk: got n=%0d want 2 words %0d,%0d", got_d.size(), r[0], r[1]);
    end
    checks++;
    if (busy !== 1'b0 || cnt_probe_ok() !== 1'b1) begin
      errors++; $display("FAIL drain_idle: got busy=%b in_ready=%b want 0 1", busy, in_ready);
    end
    w = '{4'd1, 4'd1, 4'd1, 4'd1};
    load_group(w, 4, 1'b0);
    collect(4, 8'hFF, 1'b0, 1'b0, '0);
    checks++;
    if (tmo || got_d.size() != 4) begin
      errors++; $display("FAIL ones_count: got %0d words want 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_d[i] !== 4'd1 || got_l[i] !== (i == 3)) begin
          errors++; $display("FAIL ones_word%0d: got d=%0d l=%b want d=1 l=%b", i, got_d[i], got_l[i], (i == 3));
        end
      end
    end
  endtask

  function automatic bit cnt_probe_ok();
    return in_ready;
  endfunction

  task automatic test_reset_mid_drain();
    word_t w[4], r[4];
    int k;
    w = '{4'd13, 4'd11, 4'd2, 4'd7};
    tmo = 1'b0;
    load_group(w, 4, 1'b1);
    k = 0;
    while (!out_valid && k < 10) begin @(posedge clk); #1; k++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_wait_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_drain: got v=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
    end
    w = '{4'd8, 4'd4, 4'd6, 4'd2};
    ref_sort(w, 4, r);
    load_group(w, 4, 1'b1);
    collect(4, 8'hFF, 1'b0, 1'b0, '0);
    checks++;
    if (tmo || got_d.size() != 4) begin
      errors++; $display("FAIL rst_fresh_count: got %0d words want 4", got_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_d[i] !== r[i] || got_l[i] !== (i == 3)) begin
          errors++; $display("FAIL rst_fresh_word%0d: got d=%0d l=%b want d=%0d l=%b", i, got_d[i], got_l[i], r[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    word_t w[4], r[4];
    word_t inq_d[$];
    bit    inq_l[$];
    word_t exp_d[$];
    bit    exp_l[$];
    int    exp_run[$];
    int    runs[$];
    int    n, lowrun, cyc;
    bit    acc;
    for (int g = 0; g < 6; g++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) w[i] = word_t'($urandom_range(0, 15));
      ref_sort(w, n, r);
      for (int i = 0; i < n; i++) begin
        inq_d.push_back(w[i]); inq_l.push_back(i == n - 1);
        exp_d.push_back(r[i]); exp_l.push_back(i == n - 1);
      end
      exp_run.push_back(n + 1);
    end
    got_d.delete(); got_l.delete();
    out_ready = 1'b1;
    lowrun = 0;
    cyc = 0;
    while ((inq_d.size() > 0 || got_d.size() < exp_d.size()) && cyc < 2000) begin
      in_valid = (inq_d.size() > 0);
      in_data  = (inq_d.size() > 0) ? inq_d[0] : 4'd0;
      in_last  = (inq_l.size() > 0) ? inq_l[0] : 1'b0;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_l.push_back(out_last);
      end
      if (!in_ready) lowrun++;
      else if (lowrun > 0) begin runs.push_back(lowrun); lowrun = 0; end
      @(posedge clk); #1; cyc++;
      if (acc) begin
        void'(inq_d.pop_front()); void'(inq_l.pop_front());
      end
    end
    if (in_ready && lowrun > 0) runs.push_back(lowrun);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL b2b_count: got %0d words want %0d", got_d.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
          errors++; $display("FAIL b2b_word%0d: got d=%0d l=%b want d=%0d l=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
        end
      end
    end
    checks++;
    if (runs.size() != exp_run.size()) begin
      errors++; $display("FAIL b2b_runs: got %0d busy windows want %0d", runs.size(), exp_run.size());
    end else begin
      for (int i = 0; i < runs.size(); i++) begin
        checks++;
        if (runs[i] != exp_run[i]) begin
          errors++; $display("FAIL b2b_run%0d: got in_ready low %0d cycles want %0d", i, runs[i], exp_run[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    word_t w[4], r[4];
    int n;
    bit mark;
    for (int g = 0; g < 12; g++) begin
      n = $urandom_range(1, 4);
      mark = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) w[i] = ($urandom_range(0, 3) == 0) ? 4'hF : word_t'($urandom_range(0, 15));
      ref_sort(w, n, r);
      tmo = 1'b0;
      load_group(w, n, mark);
      collect(n, 8'h00, 1'b1, 1'b0, '0);
      checks++;
      if (stable_err != 0) begin errors++; $display("FAIL rand%0d_stable: got %0d changes want 0", g, stable_err); end
      checks++;
      if (tmo || got_d.size() != n) begin
        errors++; $display("FAIL rand%0d_count: got %0d words want %0d", g, got_d.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (got_d[i] !== r[i] || got_l[i] !== (i == n - 1)) begin
            errors++; $display("FAIL rand%0d_word%0d: got d=%0d l=%b want d=%0d l=%b", g, i, got_d[i], got_l[i], r[i], (i == n - 1));
          end
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_four_word();
    test_partial();
    test_backpressure();
    test_input_during_drain();
    test_reset_mid_drain();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
